// File: rtl/write_back.sv
// Writeback stage: MEM/WB pipeline register, writeback data select, load-data wait
// with upstream stall, and a retired-instruction counter.
module write_back #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_valid,
  input  logic [1:0]             mem_wb_ctl,
  input  logic [DATA_WIDTH-1:0]  mem_alu_result,
  input  logic [4:0]             mem_rd,
  input  logic [DATA_WIDTH-1:0]  dmem_rdata,
  input  logic                   dmem_rvalid,
  output logic [4:0]             mem_wb_rd,
  output logic                   mem_wb_regwrite,
  output logic [DATA_WIDTH-1:0]  wb_mux5_writedata,
  output logic                   wb_stall,
  output logic [COUNT_WIDTH-1:0] retire_count
);

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  // WAIT_LOAD is exactly "valid load entry whose data has not arrived yet",
  // so the state register doubles as the inverse of the load-data-captured flag.
  state_t                 state_r;
  logic                   v_r;
  logic                   rw_r;
  logic                   m2r_r;
  logic [4:0]             rd_r;
  logic [DATA_WIDTH-1:0]  alu_r;
  logic [DATA_WIDTH-1:0]  ldata_r;
  logic [COUNT_WIDTH-1:0] cnt_r;
  logic                   retire_s;

  assign retire_s = v_r & (state_r == RUN);

  // Pipeline register, load wait FSM and retire counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= RUN;
      v_r     <= 1'b0;
      rw_r    <= 1'b0;
      m2r_r   <= 1'b0;
      rd_r    <= 5'd0;
      alu_r   <= {DATA_WIDTH{1'b0}};
      ldata_r <= {DATA_WIDTH{1'b0}};
      cnt_r   <= {COUNT_WIDTH{1'b0}};
    end else begin
      if (retire_s) begin
        cnt_r <= cnt_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      case (state_r)
        RUN: begin
          v_r     <= mem_valid;
          rw_r    <= mem_wb_ctl[1];
          m2r_r   <= mem_wb_ctl[0];
          rd_r    <= mem_rd;
          alu_r   <= mem_alu_result;
          ldata_r <= dmem_rdata;
          if (mem_valid && mem_wb_ctl[0] && !dmem_rvalid) begin
            state_r <= WAIT_LOAD;
          end else begin
            state_r <= RUN;
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            ldata_r <= dmem_rdata;
            state_r <= RUN;
          end else begin
            state_r <= WAIT_LOAD;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  assign wb_stall          = (state_r == WAIT_LOAD);
  assign mem_wb_regwrite   = v_r & rw_r & (rd_r != 5'd0) & ~wb_stall;
  assign wb_mux5_writedata = m2r_r ? ldata_r : alu_r;
  assign mem_wb_rd         = rd_r;
  assign retire_count      = cnt_r;

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: vector table for single-cycle retirement plus
// hand sequences for load stalls and reset during a pending load.
module tb_write_back;

  logic        clock;
  logic        reset;
  logic        mem_valid;
  logic [1:0]  mem_wb_ctl;
  logic [31:0] mem_alu_result;
  logic [4:0]  mem_rd;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_regwrite;
  logic [31:0] wb_mux5_writedata;
  logic        wb_stall;
  logic [31:0] retire_count;

  // Narrow-counter instance shares the stimulus so counter wrap is reachable.
  logic [4:0]  n_rd;
  logic        n_we;
  logic [31:0] n_wd;
  logic        n_stall;
  logic [3:0]  n_cnt;

  int passed = 0;
  int total  = 0;
  logic [31:0] model_cnt;
  logic        prev_valid;

  write_back #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_wb_ctl(mem_wb_ctl),
    .mem_alu_result(mem_alu_result), .mem_rd(mem_rd), .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid), .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .wb_mux5_writedata(wb_mux5_writedata), .wb_stall(wb_stall), .retire_count(retire_count)
  );

  write_back #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut_narrow (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_wb_ctl(mem_wb_ctl),
    .mem_alu_result(mem_alu_result), .mem_rd(mem_rd), .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid), .mem_wb_rd(n_rd), .mem_wb_regwrite(n_we),
    .wb_mux5_writedata(n_wd), .wb_stall(n_stall), .retire_count(n_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [1:0]  ctl;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        rv;
    logic        we;
    logic [4:0]  erd;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ctl, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [31:0] rdata, input logic rv);
    mem_valid = v; mem_wb_ctl = ctl; mem_alu_result = alu;
    mem_rd = rd; dmem_rdata = rdata; dmem_rvalid = rv;
  endtask

  task automatic chk_cnt(input string name);
    chk(name, retire_count, model_cnt);
    chk({name, "_narrow"}, {28'd0, n_cnt}, model_cnt & 32'h0000_000F);
  endtask

  initial begin
    //          v     ctl    alu           rd     rdata         rv    we    erd    ewd
    tbl[0] = '{1'b1, 2'b10, 32'h0000_00AA, 5'd5,  32'h0000_0000, 1'b0, 1'b1, 5'd5,  32'h0000_00AA};
    tbl[1] = '{1'b1, 2'b11, 32'h0000_0100, 5'd3,  32'h1234_5678, 1'b1, 1'b1, 5'd3,  32'h1234_5678};
    tbl[2] = '{1'b1, 2'b10, 32'h0000_0055, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0000_0055};
    tbl[3] = '{1'b1, 2'b00, 32'h0000_0044, 5'd9,  32'h0000_0000, 1'b0, 1'b0, 5'd9,  32'h0000_0044};
    tbl[4] = '{1'b0, 2'b10, 32'h0000_0077, 5'd4,  32'h0000_0000, 1'b0, 1'b0, 5'd4,  32'h0000_0077};
    tbl[5] = '{1'b1, 2'b11, 32'h0000_0001, 5'd31, 32'hCAFE_F00D, 1'b1, 1'b1, 5'd31, 32'hCAFE_F00D};
    tbl[6] = '{1'b1, 2'b10, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b1, 1'b1, 5'd1,  32'hFFFF_FFFF};
    tbl[7] = '{1'b0, 2'b11, 32'h0000_0003, 5'd2,  32'h0000_0009, 1'b0, 1'b0, 5'd2,  32'h0000_0009};
    tbl[8] = '{1'b1, 2'b01, 32'h0000_0002, 5'd6,  32'h0000_BEEF, 1'b1, 1'b0, 5'd6,  32'h0000_BEEF};

    // Reset held two cycles while MEM presents a valid instruction.
    reset = 1'b1;
    drive(1'b1, 2'b10, 32'h0000_0099, 5'd10, 32'h0000_0000, 1'b0);
    tick();
    tick();
    chk("rst_we", {31'd0, mem_wb_regwrite}, 32'd0);
    chk("rst_rd", {27'd0, mem_wb_rd}, 32'd0);
    chk("rst_wd", wb_mux5_writedata, 32'd0);
    chk("rst_stall", {31'd0, wb_stall}, 32'd0);
    model_cnt = 32'd0;
    chk_cnt("rst_cnt");

    reset = 1'b0;
    tick();
    chk("first_we", {31'd0, mem_wb_regwrite}, 32'd1);
    chk("first_rd", {27'd0, mem_wb_rd}, 32'd10);
    chk("first_wd", wb_mux5_writedata, 32'h0000_0099);
    prev_valid = 1'b1;

    // Three passes over the table; the narrow counter wraps past 15 in pass three.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 9; i++) begin
        drive(tbl[i].v, tbl[i].ctl, tbl[i].alu, tbl[i].rd, tbl[i].rdata, tbl[i].rv);
        if (prev_valid) model_cnt = model_cnt + 32'd1;
        prev_valid = tbl[i].v;
        tick();
        chk($sformatf("vec%0d_we", i), {31'd0, mem_wb_regwrite}, {31'd0, tbl[i].we});
        chk($sformatf("vec%0d_rd", i), {27'd0, mem_wb_rd}, {27'd0, tbl[i].erd});
        chk($sformatf("vec%0d_wd", i), wb_mux5_writedata, tbl[i].ewd);
        chk($sformatf("vec%0d_stall", i), {31'd0, wb_stall}, 32'd0);
        chk_cnt($sformatf("vec%0d_cnt", i));
      end
    end

    // Drain to an empty entry.
    drive(1'b0, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0);
    if (prev_valid) model_cnt = model_cnt + 32'd1;
    tick();
    chk_cnt("drain_cnt");

    // Load to x7 with data three cycles late; ALU op to x8 held upstream.
    drive(1'b1, 2'b11, 32'h0000_0333, 5'd7, 32'h1111_1111, 1'b0);
    tick();
    chk("ld_stall1", {31'd0, wb_stall}, 32'd1);
    chk("ld_we1", {31'd0, mem_wb_regwrite}, 32'd0);
    drive(1'b1, 2'b10, 32'h0000_1234, 5'd8, 32'h2222_2222, 1'b0);
    tick();
    chk("ld_stall2", {31'd0, wb_stall}, 32'd1);
    chk("ld_we2", {31'd0, mem_wb_regwrite}, 32'd0);
    tick();
    chk("ld_stall3", {31'd0, wb_stall}, 32'd1);
    chk("ld_we3", {31'd0, mem_wb_regwrite}, 32'd0);
    chk_cnt("ld_cnt_stall");
    dmem_rdata = 32'hDEAD_BEEF;
    dmem_rvalid = 1'b1;
    tick();
    chk("ld_stall_done", {31'd0, wb_stall}, 32'd0);
    chk("ld_we", {31'd0, mem_wb_regwrite}, 32'd1);
    chk("ld_rd", {27'd0, mem_wb_rd}, 32'd7);
    chk("ld_wd", wb_mux5_writedata, 32'hDEAD_BEEF);
    dmem_rvalid = 1'b0;
    model_cnt = model_cnt + 32'd1;
    tick();
    chk("held_we", {31'd0, mem_wb_regwrite}, 32'd1);
    chk("held_rd", {27'd0, mem_wb_rd}, 32'd8);
    chk("held_wd", wb_mux5_writedata, 32'h0000_1234);
    chk_cnt("held_cnt");

    // Reset in the second WAIT_LOAD cycle, then a stray dmem_rvalid pulse.
    drive(1'b1, 2'b11, 32'h0, 5'd12, 32'h0, 1'b0);
    tick();
    chk("wr_stall1", {31'd0, wb_stall}, 32'd1);
    drive(1'b0, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("wr_stall2", {31'd0, wb_stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0, 32'h5555_5555, 1'b1);
    tick();
    dmem_rvalid = 1'b0;
    model_cnt = 32'd0;
    chk("wr_we", {31'd0, mem_wb_regwrite}, 32'd0);
    chk("wr_stall", {31'd0, wb_stall}, 32'd0);
    chk("wr_rd", {27'd0, mem_wb_rd}, 32'd0);
    chk_cnt("wr_cnt");
    tick();
    chk("wr_we_after", {31'd0, mem_wb_regwrite}, 32'd0);
    chk_cnt("wr_cnt_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
